// File: rtl/mat_mul_pkg.sv
// Shared definitions for the mat_mul engine arbiter: controller states and
// row-major matrix packing helpers.
package mat_mul_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

  localparam int unsigned JobsW = 16;

  function automatic int unsigned mat_bits(input int unsigned n, input int unsigned width);
    return n * n * width;
  endfunction

  // LSB of element (i,j) in a row-major packed matrix bus.
  function automatic int unsigned elem_lsb(input int unsigned i, input int unsigned j,
                                           input int unsigned n, input int unsigned width);
    return (i * n + j) * width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr,
// wrapping past NREQ-1 back to 0.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_valid
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      // One spare bit so ptr + k never overflows before the modulo fold.
      sum = {1'b0, ptr} + (IDW + 1)'(k);
      if (sum >= (IDW + 1)'(NREQ)) begin
        sum = sum - (IDW + 1)'(NREQ);
      end
      idx = sum[IDW-1:0];
      if (!gnt_valid && req[idx]) begin
        gnt[idx]  = 1'b1;
        gnt_idx   = idx;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mat_mul_arbiter.sv
// Shares one mat_mul engine between NREQ requesters: round-robin job accept,
// start pulse, rising-edge completion capture, and per-requester response.
module mat_mul_arbiter
  import mat_mul_pkg::*;
#(
  parameter int unsigned width = 32,
  parameter int unsigned n     = 3,
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDW   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*n*n*width-1:0] req_a,
  input  logic [NREQ*n*n*width-1:0] req_b,
  output logic [NREQ-1:0]           rsp_valid,
  input  logic [NREQ-1:0]           rsp_ready,
  output logic [n*n*width-1:0]      rsp_c,
  output logic                      mm_start,
  output logic [n*n*width-1:0]      mm_a,
  output logic [n*n*width-1:0]      mm_b,
  input  logic [n*n*width-1:0]      mm_c,
  input  logic                      mm_done,
  output logic                      busy,
  output logic [IDW-1:0]            grant_id,
  output logic [JobsW-1:0]          jobs_done
);

  localparam int unsigned MatBits = mat_bits(n, width);

  state_e              state_q;
  logic [IDW-1:0]      rr_ptr_q;
  logic [IDW-1:0]      grant_id_q;
  logic                mm_start_q;
  logic                busy_q;
  logic [NREQ-1:0]     rsp_valid_q;
  logic [JobsW-1:0]    jobs_done_q;
  logic [MatBits-1:0]  mm_a_q;
  logic [MatBits-1:0]  mm_b_q;
  logic [MatBits-1:0]  res_q;
  logic                done_q;

  logic [NREQ-1:0]     gnt;
  logic [IDW-1:0]      gnt_idx;
  logic                gnt_valid;
  logic                done_rise;
  logic                rsp_fire;
  logic [IDW-1:0]      next_ptr;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // A done level left high by the previous job must not complete the next one.
  assign done_rise = mm_done & ~done_q;
  assign rsp_fire  = rsp_ready[grant_id_q];
  assign next_ptr  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      mm_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= '0;
      jobs_done_q <= '0;
      mm_a_q      <= '0;
      mm_b_q      <= '0;
      res_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= mm_done;
      unique case (state_q)
        StIdle: begin
          if (gnt_valid) begin
            mm_a_q     <= req_a[32'(gnt_idx) * MatBits +: MatBits];
            mm_b_q     <= req_b[32'(gnt_idx) * MatBits +: MatBits];
            grant_id_q <= gnt_idx;
            rr_ptr_q   <= next_ptr;
            mm_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          mm_start_q <= 1'b0;
          state_q    <= StWait;
        end
        StWait: begin
          if (done_rise) begin
            res_q       <= mm_c;
            rsp_valid_q <= NREQ'(1) << grant_id_q;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (rsp_fire) begin
            rsp_valid_q <= '0;
            jobs_done_q <= jobs_done_q + JobsW'(1);
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Ready is the only combinational output: the accept happens in the same cycle.
  assign req_ready = (state_q == StIdle && !rst) ? gnt : '0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_c     = res_q;
  assign mm_start  = mm_start_q;
  assign mm_a      = mm_a_q;
  assign mm_b      = mm_b_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;
  assign jobs_done = jobs_done_q;

  a_req_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_rsp_valid_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_valid));
  a_start_single:     assert property (@(posedge clk) disable iff (rst) mm_start |=> !mm_start);

endmodule

// File: tb/tb_mat_mul_arbiter.sv
// Directed bench for mat_mul_arbiter with a behavioural mat_mul engine whose
// latency and done style (pulse or held level) are set per job.
module tb_mat_mul_arbiter;
  import mat_mul_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 3;
  localparam int unsigned NR = 2;
  localparam int unsigned IW = 1;
  localparam int unsigned MB = N * N * W;

  typedef logic [MB-1:0] mat_t;

  typedef struct {
    logic [NR-1:0] valid;
    mat_t          a0, b0, a1, b1;
    int unsigned   id;
    mat_t          c;
    logic [15:0]   jobs;
    int unsigned   lat;
    bit            lvl;
    int unsigned   hold;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*MB-1:0] req_a;
  logic [NR*MB-1:0] req_b;
  logic [NR-1:0]    rsp_valid;
  logic [NR-1:0]    rsp_ready;
  mat_t             rsp_c;
  logic             mm_start;
  mat_t             mm_a;
  mat_t             mm_b;
  mat_t             mm_c;
  logic             mm_done;
  logic             busy;
  logic [IW-1:0]    grant_id;
  logic [15:0]      jobs_done;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  mat_mul_arbiter #(
    .width (W),
    .n     (N),
    .NREQ  (NR),
    .IDW   (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_c     (rsp_c),
    .mm_start  (mm_start),
    .mm_a      (mm_a),
    .mm_b      (mm_b),
    .mm_c      (mm_c),
    .mm_done   (mm_done),
    .busy      (busy),
    .grant_id  (grant_id),
    .jobs_done (jobs_done)
  );

  function automatic mat_t mk(input logic [31:0] e0, e1, e2, e3, e4, e5, e6, e7, e8);
    return {e8, e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  function automatic mat_t matmul(input mat_t a, input mat_t b);
    mat_t        c;
    logic [W-1:0] s;
    c = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = '0;
        for (int k = 0; k < N; k++) begin
          s = s + a[elem_lsb(i, k, N, W) +: W] * b[elem_lsb(k, j, N, W) +: W];
        end
        c[elem_lsb(i, j, N, W) +: W] = s;
      end
    end
    return c;
  endfunction

  function automatic vec_t row(input logic [NR-1:0] valid, input mat_t a0, b0, a1, b1,
                               input int unsigned id, input mat_t c, input logic [15:0] jobs,
                               input int unsigned lat, input bit lvl, input int unsigned hold);
    vec_t v;
    v.valid = valid; v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1;
    v.id = id; v.c = c; v.jobs = jobs; v.lat = lat; v.lvl = lvl; v.hold = hold;
    return v;
  endfunction

  // Engine model: lat 0 answers on the start edge; level mode keeps the old
  // done/result visible for the first cycles of the next job.
  int unsigned eng_lat = 2;
  bit          eng_lvl = 1'b0;
  int unsigned eng_cnt;
  mat_t        eng_a, eng_b;

  always @(posedge clk) begin
    if (rst) begin
      eng_cnt <= 0;
      mm_done <= 1'b0;
      mm_c    <= '0;
    end else if (mm_start) begin
      eng_a <= mm_a;
      eng_b <= mm_b;
      if (eng_lat == 0) begin
        mm_done <= 1'b1;
        mm_c    <= matmul(mm_a, mm_b);
        eng_cnt <= 0;
      end else begin
        eng_cnt <= eng_lat;
        if (!eng_lvl) mm_done <= 1'b0;
      end
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 2) mm_done <= 1'b0;
      if (eng_cnt == 1) begin
        mm_done <= 1'b1;
        mm_c    <= matmul(eng_a, eng_b);
      end
    end else if (!eng_lvl) begin
      mm_done <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (mm_start === 1'b1) start_cnt <= start_cnt + 1;
  end

  task automatic check(input string name, input mat_t act, input mat_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic serve(input vec_t v, input string tag);
    logic [NR-1:0] oh;
    mat_t          c_seen;
    int            sc;
    bit            ready_bad, timeout, unstable;
    oh = NR'(1) << v.id;
    @(negedge clk);
    eng_lat   = v.lat;
    eng_lvl   = v.lvl;
    req_a     = {v.a1, v.a0};
    req_b     = {v.b1, v.b0};
    req_valid = v.valid;
    rsp_ready = '0;
    sc        = start_cnt;
    #1;
    check({tag, " req_ready"}, req_ready, oh);
    @(posedge clk);
    #1;
    check({tag, " grant_id"}, grant_id, v.id);
    check({tag, " busy"}, busy, 1);
    check({tag, " mm_start"}, mm_start, 1);
    check({tag, " mm_a"}, mm_a, (v.id == 0) ? v.a0 : v.a1);
    check({tag, " mm_b"}, mm_b, (v.id == 0) ? v.b0 : v.b1);
    req_valid = v.valid & ~oh;
    ready_bad = 1'b0;
    timeout   = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready != '0) ready_bad = 1'b1;
      if (rsp_valid != '0) begin
        timeout = 1'b0;
        break;
      end
    end
    check({tag, " rsp timeout"}, timeout, 0);
    check({tag, " req_ready while busy"}, ready_bad, 0);
    check({tag, " rsp_valid"}, rsp_valid, oh);
    check({tag, " rsp_c"}, rsp_c, v.c);
    c_seen   = rsp_c;
    unstable = 1'b0;
    rsp_ready = ~oh;
    for (int i = 0; i < int'(v.hold) + 1; i++) begin
      @(negedge clk);
      if (rsp_valid != oh || rsp_c != c_seen || req_ready != '0) unstable = 1'b1;
    end
    check({tag, " rsp held stable"}, unstable, 0);
    rsp_ready = oh;
    @(posedge clk);
    #1;
    rsp_ready = '0;
    check({tag, " jobs_done"}, jobs_done, v.jobs);
    check({tag, " rsp_valid cleared"}, rsp_valid, 0);
    check({tag, " busy cleared"}, busy, 0);
    check({tag, " start pulses"}, start_cnt - sc, 1);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mat_t m19, m91, eye, junk, d2, hi, c1, c2x, zero;
    vec_t vecs [13];
    bit   reached, seen;

    m19  = mk(1, 2, 3, 4, 5, 6, 7, 8, 9);
    m91  = mk(9, 8, 7, 6, 5, 4, 3, 2, 1);
    eye  = mk(1, 0, 0, 0, 1, 0, 0, 0, 1);
    junk = mk(7, 7, 7, 7, 7, 7, 7, 7, 7);
    d2   = mk(2, 0, 0, 0, 2, 0, 0, 0, 2);
    hi   = mk(32'h8000_0000, 0, 0, 0, 32'h8000_0000, 0, 0, 0, 32'h8000_0000);
    c1   = mk(30, 24, 18, 84, 69, 54, 138, 114, 90);
    c2x  = mk(2, 4, 6, 8, 10, 12, 14, 16, 18);
    zero = '0;

    //             valid  a0    b0    a1    b1    id c     jobs lat lvl hold
    vecs[0]  = row(2'b01, m19,  m91,  junk, junk, 0, c1,   1,   3, 0,  0);
    vecs[1]  = row(2'b10, junk, junk, eye,  m91,  1, m91,  2,   3, 0,  0);
    vecs[2]  = row(2'b01, d2,   m19,  junk, junk, 0, c2x,  3,   1, 0,  0);
    vecs[3]  = row(2'b10, junk, junk, hi,   d2,   1, zero, 4,   0, 0,  0);
    vecs[4]  = row(2'b11, m19,  m91,  eye,  m91,  0, c1,   5,   3, 0,  0);
    vecs[5]  = row(2'b11, m19,  m91,  eye,  m91,  1, m91,  6,   3, 0,  0);
    vecs[6]  = row(2'b11, m19,  m91,  eye,  m91,  0, c1,   7,   3, 0,  0);
    vecs[7]  = row(2'b11, m19,  m91,  eye,  m91,  1, m91,  8,   3, 0,  0);
    vecs[8]  = row(2'b11, m19,  m91,  eye,  m91,  0, c1,   9,   3, 0, 20);
    vecs[9]  = row(2'b10, m19,  m91,  eye,  m91,  1, m91,  10,  3, 0,  0);
    vecs[10] = row(2'b01, m19,  m91,  junk, junk, 0, c1,   11,  4, 1,  0);
    vecs[11] = row(2'b01, d2,   m19,  junk, junk, 0, c2x,  12,  4, 1,  0);
    vecs[12] = row(2'b01, eye,  m19,  junk, junk, 0, m19,  13,  2, 0,  0);

    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset req_ready", req_ready, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset mm_start", mm_start, 0);
    check("reset busy", busy, 0);
    check("reset grant_id", grant_id, 0);
    check("reset jobs_done", jobs_done, 0);
    check("reset rsp_c", rsp_c, 0);
    check("reset mm_a", mm_a, 0);

    for (int i = 0; i < 13; i++) begin
      serve(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while the engine is still working drops the job and its response.
    @(negedge clk);
    eng_lat   = 10;
    eng_lvl   = 1'b0;
    req_a     = {junk, m19};
    req_b     = {junk, m91};
    req_valid = 2'b01;
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (3) @(negedge clk);
    check("midwait busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midwait rst busy", busy, 0);
    check("midwait rst rsp_valid", rsp_valid, 0);
    check("midwait rst jobs_done", jobs_done, 0);
    check("midwait rst grant_id", grant_id, 0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid != '0 || busy) seen = 1'b1;
    end
    check("midwait dropped job stays dropped", seen, 0);
    serve(row(2'b11, m19, m91, eye, m91, 0, c1, 1, 2, 0, 0), "post-reset first");
    serve(row(2'b11, m19, m91, eye, m91, 1, m91, 2, 2, 0, 0), "post-reset second");

    // Run back-to-back jobs through a zero-latency engine until the counter wraps.
    @(negedge clk);
    eng_lat   = 0;
    eng_lvl   = 1'b0;
    req_a     = {eye, eye};
    req_b     = {eye, eye};
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    reached   = 1'b0;
    for (int i = 0; i < 300000; i++) begin
      @(negedge clk);
      if (jobs_done == 16'hFFFF) begin
        reached = 1'b1;
        break;
      end
    end
    check("wrap reached 0xffff", reached, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (jobs_done != 16'hFFFF) break;
    end
    check("wrap jobs_done to zero", jobs_done, 0);
    req_valid = '0;
    rsp_ready = '0;
    repeat (10) @(negedge clk);
    check("wrap idle busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
